// File: rtl/proc.sv
// Processor-wide constants and the store-buffer entry type.
// Exports ARCH_BITS, BYTE_BITS, REG_IDX_BITS, SB_SLOTS, SB_IDX_BITS, BYTE_IDX_BITS, sb_entry_t, sb_store_data().
package proc;

    localparam int ARCH_BITS     = 32;
    localparam int BYTE_BITS     = 8;
    localparam int REG_IDX_BITS  = 5;
    localparam int SB_SLOTS      = 4;
    localparam int SB_IDX_BITS   = $clog2(SB_SLOTS);
    localparam int BYTE_IDX_BITS = $clog2(ARCH_BITS / BYTE_BITS);

    typedef struct packed {
        logic [ARCH_BITS-1:0] addr;
        logic [ARCH_BITS-1:0] data;
        logic                 is_byte;
    } sb_entry_t;

    // Byte stores keep only the low byte so stale upper bits
    // never reach the cache or the forwarding path.
    function automatic logic [ARCH_BITS-1:0] sb_store_data(
        input logic [ARCH_BITS-1:0] data,
        input logic                 is_byte
    );
        logic [ARCH_BITS-1:0] r;
        r = data;
        if (is_byte) begin
            r = {{(ARCH_BITS-BYTE_BITS){1'b0}}, data[BYTE_BITS-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Age-ordered word match across store buffer slots.
// In: valid, addr[], head_idx, lookup_addr. Out: hit, hit_idx (youngest match).
module store_buffer_match
    import proc::*;
#(
    parameter int SLOTS    = proc::SB_SLOTS,
    parameter int IDX_BITS = proc::SB_IDX_BITS,
    parameter int BYTE_IDX = proc::BYTE_IDX_BITS
) (
    input  logic [SLOTS-1:0]                valid,
    input  logic [SLOTS-1:0][ARCH_BITS-1:0] addr,
    input  logic [IDX_BITS-1:0]             head_idx,
    input  logic [ARCH_BITS-1:0]            lookup_addr,
    output logic                            hit,
    output logic [IDX_BITS-1:0]             hit_idx
);

    logic [IDX_BITS-1:0] slot;
    logic                unused_low;

    // Walk oldest to youngest; a later match overwrites an
    // earlier one, so the youngest matching store wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = head_idx;
        slot    = head_idx;
        for (int k = 0; k < SLOTS; k++) begin
            slot = head_idx + IDX_BITS'(k);
            if (valid[slot] &&
                addr[slot][ARCH_BITS-1:BYTE_IDX] ==
                lookup_addr[ARCH_BITS-1:BYTE_IDX]) begin
                hit     = 1'b1;
                hit_idx = slot;
            end
        end
    end

    // Byte offsets are deliberately ignored by the word compare.
    always_comb begin
        unused_low = ^lookup_addr[BYTE_IDX-1:0];
        for (int k = 0; k < SLOTS; k++) begin
            unused_low = unused_low ^ (^addr[k][BYTE_IDX-1:0]);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store FIFO draining to dCache, with load forwarding lookup.
// In: inValid/inAddress/inData/inByte, memAck, lookupReq/lookupAddr. Out: full/empty/count/overflow, mem*, lookup*.
module store_buffer
    import proc::*;
#(
    parameter int SB_SLOTS      = proc::SB_SLOTS,
    parameter int SB_IDX_BITS   = proc::SB_IDX_BITS,
    parameter int BYTE_IDX_BITS = proc::BYTE_IDX_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inValid,
    input  logic [ARCH_BITS-1:0]   inAddress,
    input  logic [ARCH_BITS-1:0]   inData,
    input  logic                   inByte,
    output logic                   full,
    output logic                   empty,
    output logic [SB_IDX_BITS:0]   count,
    output logic                   overflow,
    output logic                   memReq,
    output logic [ARCH_BITS-1:0]   memAddress,
    output logic [ARCH_BITS-1:0]   memData,
    output logic                   memByte,
    input  logic                   memAck,
    input  logic                   lookupReq,
    input  logic [ARCH_BITS-1:0]   lookupAddr,
    output logic                   lookupHit,
    output logic [ARCH_BITS-1:0]   lookupData,
    output logic [ARCH_BITS-1:0]   lookupAddrOut,
    output logic                   lookupByte
);

    localparam int CNT_BITS = SB_IDX_BITS + 1;

    sb_entry_t                         slots [SB_SLOTS];
    logic [SB_SLOTS-1:0]               valid_q;
    logic [SB_IDX_BITS-1:0]            head_q;
    logic [SB_IDX_BITS-1:0]            tail_q;
    logic [CNT_BITS-1:0]               count_q;
    logic                              overflow_q;
    logic                              enq;
    logic                              deq;
    logic [SB_SLOTS-1:0][ARCH_BITS-1:0] slot_addr;
    logic                              match_hit;
    logic [SB_IDX_BITS-1:0]            match_idx;

    // count disambiguates head==tail between empty and full.
    assign full     = (count_q == CNT_BITS'(SB_SLOTS));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;

    assign memReq     = !empty;
    assign memAddress = slots[head_q].addr;
    assign memData    = slots[head_q].data;
    assign memByte    = slots[head_q].is_byte;

    // Eligibility uses full as registered: an ack arriving in the
    // same cycle does not open a slot for the incoming store.
    assign enq = inValid && !full;
    assign deq = memReq && memAck;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + CNT_BITS'(enq) - CNT_BITS'(deq);
            if (inValid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (enq) begin
            slots[tail_q] <= '{
                addr:    inAddress,
                data:    sb_store_data(inData, inByte),
                is_byte: inByte
            };
        end
    end

    always_comb begin
        slot_addr = '0;
        for (int i = 0; i < SB_SLOTS; i++) begin
            slot_addr[i] = slots[i].addr;
        end
    end

    store_buffer_match #(
        .SLOTS    (SB_SLOTS),
        .IDX_BITS (SB_IDX_BITS),
        .BYTE_IDX (BYTE_IDX_BITS)
    ) u_match (
        .valid       (valid_q),
        .addr        (slot_addr),
        .head_idx    (head_q),
        .lookup_addr (lookupAddr),
        .hit         (match_hit),
        .hit_idx     (match_idx)
    );

    assign lookupHit     = lookupReq && match_hit;
    assign lookupData    = slots[match_idx].data;
    assign lookupAddrOut = slots[match_idx].addr;
    assign lookupByte    = slots[match_idx].is_byte;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer against a queue model.
// Model holds committed stores as a FIFO queue; checks every cycle.
module tb_store_buffer;
    import proc::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [31:0] inAddress;
    logic [31:0] inData;
    logic        inByte;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        memReq;
    logic [31:0] memAddress;
    logic [31:0] memData;
    logic        memByte;
    logic        memAck;
    logic        lookupReq;
    logic [31:0] lookupAddr;
    logic        lookupHit;
    logic [31:0] lookupData;
    logic [31:0] lookupAddrOut;
    logic        lookupByte;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .inValid       (inValid),
        .inAddress     (inAddress),
        .inData        (inData),
        .inByte        (inByte),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .memReq        (memReq),
        .memAddress    (memAddress),
        .memData       (memData),
        .memByte       (memByte),
        .memAck        (memAck),
        .lookupReq     (lookupReq),
        .lookupAddr    (lookupAddr),
        .lookupHit     (lookupHit),
        .lookupData    (lookupData),
        .lookupAddrOut (lookupAddrOut),
        .lookupByte    (lookupByte)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        b;
    } ent_t;

    ent_t q[$];
    bit   ovf_m = 1'b0;
    int   errs = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input bit v, input logic [31:0] a,
                       input logic [31:0] d, input bit b, input bit ack);
        inValid   = v;
        inAddress = a;
        inData    = d;
        inByte    = b;
        memAck    = ack;
    endtask

    task automatic look(input bit r, input logic [31:0] a);
        lookupReq  = r;
        lookupAddr = a;
    endtask

    // Check outputs mid-cycle against the model, then advance the
    // model by the events the coming rising edge will commit.
    task automatic cycle();
        int   n;
        bit   hit;
        ent_t h;
        @(negedge clk);
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == 4));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("memReq", 32'(memReq), 32'(n != 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (n != 0) begin
            chk("memAddress", memAddress, q[0].a);
            chk("memData", memData, q[0].d);
            chk("memByte", 32'(memByte), 32'(q[0].b));
        end
        hit = 1'b0;
        h   = '{a: 0, d: 0, b: 0};
        if (lookupReq) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (!hit && q[i].a[31:2] == lookupAddr[31:2]) begin
                    hit = 1'b1;
                    h   = q[i];
                end
            end
        end
        chk("lookupHit", 32'(lookupHit), 32'(hit));
        if (hit) begin
            chk("lookupData", lookupData, h.d);
            chk("lookupAddrOut", lookupAddrOut, h.a);
            chk("lookupByte", 32'(lookupByte), 32'(h.b));
        end
        if (rst) begin
            if (inValid && n == 4) ovf_m = 1'b1;
            if (n != 0 && memAck) void'(q.pop_front());
            if (inValid && n < 4)
                q.push_back('{a: inAddress,
                              d: inByte ? {24'h0, inData[7:0]} : inData,
                              b: inByte});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drv(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle();
        drv(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        drv(0, 0, 0, 0, 0);
        look(0, 0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();

        // single word store, held 3 cycles, then acked
        drv(1, 32'h100, 32'hDEADBEEF, 0, 0);
        cycle();
        drv(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle();
        drv(0, 0, 0, 0, 1);
        cycle();
        drv(0, 0, 0, 0, 0);
        cycle();

        // fill to full, overflow attempt, in-order drain
        for (int i = 0; i < 5; i++) begin
            drv(1, 32'h400 + 32'(i * 4), 32'h1000 + 32'(i), 0, 0);
            cycle();
        end
        drain();

        // full with simultaneous inValid and ack
        for (int i = 0; i < 4; i++) begin
            drv(1, 32'h500 + 32'(i * 4), 32'h2000 + 32'(i), i[0], 0);
            cycle();
        end
        drv(1, 32'h5F0, 32'h3333, 0, 1);
        cycle();
        drain();

        // steady enq+ack: count stays 1, pointers wrap
        drv(1, 32'h600, 32'h6000, 0, 1);
        cycle();
        for (int i = 1; i <= 10; i++) begin
            drv(1, 32'h600 + 32'(i * 4), 32'h6000 + 32'(i), 0, 1);
            cycle();
        end
        drain();

        // forwarding: youngest byte store wins over word store
        drv(1, 32'h200, 32'h11111111, 0, 0);
        cycle();
        drv(1, 32'h201, 32'h000000AA, 1, 0);
        cycle();
        drv(0, 0, 0, 0, 0);
        look(1, 32'h203);
        cycle();
        look(1, 32'h204);
        cycle();
        look(0, 32'h203);
        cycle();
        drain();

        // async reset mid-drain with count 2
        drv(1, 32'h700, 32'h7777, 0, 0);
        cycle();
        drv(1, 32'h704, 32'h7778, 0, 0);
        cycle();
        drv(0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        q.delete();
        ovf_m = 1'b0;
        cycle();
        rst = 1'b1;
        drv(0, 0, 0, 0, 1);
        cycle();
        cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drv($urandom_range(0, 1),
                32'h300 + 32'($urandom_range(0, 15)),
                $urandom,
                $urandom_range(0, 1),
                ($urandom_range(0, 2) == 0));
            look($urandom_range(0, 1),
                 32'h300 + 32'($urandom_range(0, 15)));
            cycle();
        end
        drv(0, 0, 0, 0, 0);
        look(0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
